// File: rtl/ssd_scan.sv
// ssd_scan: multiplexed seven-segment display scanner.
//   A prescaler p divides clk_1M into digit slots of REFRESH_DIV cycles.
//   A digit index k steps through N_DIGITS slots; one full pass is a frame.
//   digits/dp/blank are captured into a pending set on load. The pending set
//   is copied to the active set only at a frame wrap, so a frame never mixes
//   old and new values.
// Ports:
//   clk_1M     in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   digits     in   4*N_DIGITS hex nibbles, nibble 0 is the rightmost digit
//   dp         in   per-digit decimal point request
//   blank      in   per-digit force-off
//   load       in   snapshot strobe for digits/dp/blank
//   seg_en     out  one-hot-or-zero digit enable, active high
//   seg        out  segments gfedcba (bit0 = a), 1 = lit
//   seg_dp     out  decimal point segment, 1 = lit
//   frame_done out  one-cycle pulse in the cycle after each frame wrap
module ssd_scan #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int DEAD_CYCLES = 8,
  parameter int LZS         = 0
) (
  input  logic                    clk_1M,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     dp,
  input  logic [N_DIGITS-1:0]     blank,
  input  logic                    load,
  output logic [N_DIGITS-1:0]     seg_en,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int KW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // scan state
  logic [PW-1:0] p_q, p_d;
  logic [KW-1:0] k_q, k_d;
  // pending and active register sets
  logic [4*N_DIGITS-1:0] pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]   pend_bl_q, pend_bl_d, act_bl_q, act_bl_d;
  logic                  pend_vld_q, pend_vld_d;
  // registered outputs
  logic [N_DIGITS-1:0]   seg_en_q, seg_en_d;
  logic [6:0]            seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic                  frame_done_q, frame_done_d;

  logic p_wrap, frame_wrap, dead;

  generate
    if (DEAD_CYCLES == 0) begin : g_nodead
      assign dead = 1'b0;
    end else begin : g_dead
      assign dead = (p_q < PW'(DEAD_CYCLES));
    end
  endgenerate

  assign p_wrap     = (p_q == P_LAST);
  assign frame_wrap = p_wrap && (k_q == K_LAST);

  // scan counters and register-set transfer
  always_comb begin
    p_d = p_wrap ? '0 : p_q + 1'b1;
    k_d = k_q;
    if (p_wrap) k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;

    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_bl_d  = pend_bl_q;
    pend_vld_d = pend_vld_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    act_bl_d   = act_bl_q;

    if (load) begin
      pend_dig_d = digits;
      pend_dp_d  = dp;
      pend_bl_d  = blank;
      pend_vld_d = 1'b1;
    end

    // A load coinciding with the wrap goes straight to active; it is consumed,
    // so pending_valid ends up clear either way.
    if (frame_wrap && (pend_vld_q || load)) begin
      act_dig_d  = load ? digits : pend_dig_q;
      act_dp_d   = load ? dp     : pend_dp_q;
      act_bl_d   = load ? blank  : pend_bl_q;
      pend_vld_d = 1'b0;
    end
  end

  // output decode from the current slot
  always_comb begin
    logic [3:0] nib;
    logic       dpk, blk, zero_hi, supp;
    logic [N_DIGITS-1:0] onehot;
    nib     = '0;
    dpk     = 1'b0;
    blk     = 1'b0;
    supp    = 1'b0;
    zero_hi = 1'b1;
    onehot  = '0;
    // walk from the top digit down so zero_hi means "this and all higher are 0"
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_hi = zero_hi && (act_dig_q[4*i +: 4] == 4'h0);
      if (k_q == KW'(i)) begin
        nib       = act_dig_q[4*i +: 4];
        dpk       = act_dp_q[i];
        blk       = act_bl_q[i];
        onehot[i] = 1'b1;
        supp      = (LZS != 0) && (i != 0) && zero_hi;
      end
    end

    seg_en_d = '0;
    seg_d    = '0;
    seg_dp_d = 1'b0;
    if (!dead && !blk) begin
      seg_en_d = onehot;
      seg_d    = supp ? 7'h00 : hex7(nib);
      seg_dp_d = dpk;
    end
    frame_done_d = frame_wrap;
  end

  always_ff @(posedge clk_1M) begin
    if (rst) begin
      p_q          <= '0;
      k_q          <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_bl_q    <= '0;
      pend_vld_q   <= 1'b0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_bl_q     <= '0;
      seg_en_q     <= '0;
      seg_q        <= '0;
      seg_dp_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      k_q          <= k_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_bl_q    <= pend_bl_d;
      pend_vld_q   <= pend_vld_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      act_bl_q     <= act_bl_d;
      seg_en_q     <= seg_en_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_en     = seg_en_q;
  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan.sv
// tb_ssd_scan: randomized bench for ssd_scan with a cycle-level reference
// model. Two instances share stimulus: one without and one with leading-zero
// suppression.
module tb_ssd_scan;
  localparam int N = 4;
  localparam int R = 4;
  localparam int D = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4*N-1:0] digits = '0;
  logic [N-1:0]  dp = '0, blank = '0;
  logic          load = 1'b0;
  logic [N-1:0]  seg_en0, seg_en1;
  logic [6:0]    seg0, seg1;
  logic          seg_dp0, seg_dp1, fd0, fd1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ssd_scan #(.N_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .LZS(0)) u_plain (
    .clk_1M(clk), .rst(rst), .digits(digits), .dp(dp), .blank(blank), .load(load),
    .seg_en(seg_en0), .seg(seg0), .seg_dp(seg_dp0), .frame_done(fd0));

  ssd_scan #(.N_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .LZS(1)) u_lzs (
    .clk_1M(clk), .rst(rst), .digits(digits), .dp(dp), .blank(blank), .load(load),
    .seg_en(seg_en1), .seg(seg1), .seg_dp(seg_dp1), .frame_done(fd1));

  // reference model state
  int          mp = 0, mk = 0;
  logic [15:0] a_dig = '0, p_dig = '0;
  logic [3:0]  a_dp = '0, a_bl = '0, p_dp = '0, p_bl = '0;
  bit          pv = 0;
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
    end
  endtask

  // {seg_en[3:0], seg[6:0], seg_dp} for the slot the model is in now
  function automatic logic [11:0] model_out(input bit lzs);
    logic [3:0] nib;
    bit supp;
    if (mp < D || a_bl[mk]) return 12'h000;
    nib  = 4'((a_dig >> (4 * mk)) & 16'hF);
    supp = lzs && (mk >= 1) && ((a_dig >> (4 * mk)) == 16'h0);
    return {4'(1 << mk), supp ? 7'h00 : hex_tab[nib], a_dp[mk]};
  endfunction

  task automatic model_update();
    bit fw;
    if (rst) begin
      mp = 0; mk = 0; a_dig = '0; a_dp = '0; a_bl = '0;
      p_dig = '0; p_dp = '0; p_bl = '0; pv = 0;
      return;
    end
    fw = (mp == R - 1) && (mk == N - 1);
    if (fw && (pv || load)) begin
      a_dig = load ? digits : p_dig;
      a_dp  = load ? dp : p_dp;
      a_bl  = load ? blank : p_bl;
    end
    if (load) begin
      p_dig = digits; p_dp = dp; p_bl = blank; pv = 1;
    end
    if (fw) pv = 0;
    if (mp == R - 1) begin
      mp = 0;
      mk = (mk + 1) % N;
    end else begin
      mp++;
    end
  endtask

  // one clock: expectation from the pre-edge model, compared after the edge
  task automatic step();
    logic [11:0] e0, e1;
    logic efd;
    if (rst) begin
      e0 = '0; e1 = '0; efd = 1'b0;
    end else begin
      e0 = model_out(0); e1 = model_out(1);
      efd = (mp == R - 1) && (mk == N - 1);
    end
    @(posedge clk); #1;
    model_update();
    chk("seg_en",     32'(seg_en0), 32'(e0[11:8]));
    chk("seg",        32'(seg0),    32'(e0[7:1]));
    chk("seg_dp",     32'(seg_dp0), 32'(e0[0]));
    chk("frame_done", 32'(fd0),     32'(efd));
    chk("lzs_seg_en", 32'(seg_en1), 32'(e1[11:8]));
    chk("lzs_seg",    32'(seg1),    32'(e1[7:1]));
    chk("lzs_seg_dp", 32'(seg_dp1), 32'(e1[0]));
    chk("lzs_fd",     32'(fd1),     32'(efd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits = d; dp = p; blank = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    // reset, with a load that must be discarded
    rst = 1'b1; load = 1'b1; digits = 16'hFFFF; dp = 4'hF;
    step(); step();
    load = 1'b0; rst = 1'b0;

    // basic frame: 12AF with dp on digit 2
    do_load(16'h12AF, 4'b0100, 4'b0000);
    run(40);

    // mid-frame load at k=1
    for (int i = 0; i < 32 && mk != 1; i++) step();
    do_load(16'h3456, 4'b0001, 4'b0000);
    run(36);

    // load that coincides with the wrap wins over an earlier pending load
    do_load(16'h1111, 4'b0000, 4'b0000);
    for (int i = 0; i < 64 && !(mp == R - 1 && mk == N - 1); i++) step();
    do_load(16'h2222, 4'b0000, 4'b0000);
    run(20);

    // blanking of digits 1 and 3
    do_load(16'h8888, 4'b1111, 4'b1010);
    run(36);

    // leading-zero suppression patterns
    do_load(16'h0070, 4'b1000, 4'b0000);
    run(36);
    do_load(16'h0000, 4'b0000, 4'b0000);
    run(36);
    do_load(16'h0B00, 4'b0110, 4'b0000);
    run(36);

    // one-cycle reset at k=2, p=2
    for (int i = 0; i < 64 && !(mk == 2 && mp == 2); i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    run(24);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      for (int j = 0; j < N; j++) d[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      digits = d;
      dp     = 4'($urandom);
      blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      load   = ($urandom_range(0, 7) == 0);
      rst    = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
